// File: rtl/trap_ctrl_pkg.sv
// Shared types for the trap sequencer: exception causes, CSR effect record,
// sequencer states and request kind.
package trap_ctrl_pkg;

  typedef enum logic [3:0] {
    INSTR_MISALIGN = 4'd0,
    INSTR_FAULT    = 4'd1,
    ILLEGAL_INSTR  = 4'd2,
    BREAKPOINT     = 4'd3,
    LOAD_MISALIGN  = 4'd4,
    LOAD_FAULT     = 4'd5,
    STORE_MISALIGN = 4'd6,
    STORE_FAULT    = 4'd7,
    ECALL_M        = 4'd11
  } ex_cause;

  typedef enum logic [1:0] {
    CSR_EFF_NONE    = 2'd0,
    CSR_EFF_EX      = 2'd1,
    CSR_EFF_RET     = 2'd2,
    CSR_EFF_INSTRET = 2'd3
  } csr_eff_t;

  typedef struct packed {
    csr_eff_t    t;
    ex_cause     src;
    logic [31:0] epc;
    logic [31:0] tval;
  } csr_effect;

  typedef enum logic [2:0] {IDLE, FLUSH, DRAIN, EFFECT, REDIRECT} trap_state_e;
  typedef enum logic {EX, RET} trap_kind_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// Commit / CSR-file / fetch side signals of the trap sequencer.
// slave: the sequencer itself; master: whoever drives commit, LSU, CSR and fetch.
interface trap_ctrl_if;
  import trap_ctrl_pkg::*;

  logic        trap_valid;
  ex_cause     trap_cause;
  logic [31:0] trap_epc;
  logic [31:0] trap_tval;
  logic        mret_valid;
  logic        req_ready;
  logic        retire;
  logic        lsu_idle;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        flush;
  csr_effect   effect;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;
  logic        busy;

  modport slave (
    input  trap_valid, trap_cause, trap_epc, trap_tval, mret_valid,
    input  retire, lsu_idle, csr_mtvec, csr_mepc, redir_ready,
    output req_ready, flush, effect, redir_valid, redir_pc, busy
  );

  modport master (
    output trap_valid, trap_cause, trap_epc, trap_tval, mret_valid,
    output retire, lsu_idle, csr_mtvec, csr_mepc, redir_ready,
    input  req_ready, flush, effect, redir_valid, redir_pc, busy
  );

endinterface

// File: rtl/trap_ctrl.sv
// Trap / mret sequencer: accept request, flush, drain, issue one CSR effect,
// redirect fetch. Retire pulses are forwarded as INSTRET effects, deferred by
// a small counter when they collide with the EX/RET effect cycle.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int PEND_W       = 2
) (
  input logic        clk,
  input logic        rst,
  trap_ctrl_if.slave bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  trap_state_e       state, state_n;
  logic [CNT_W-1:0]  fcnt;
  trap_kind_e        kind;
  ex_cause           cause;
  logic [31:0]       epc, tval, redir_pc_q;
  logic [PEND_W-1:0] pend;
  logic              accept;
  logic              req_ready, busy, flush, redir_valid;
  csr_effect         eff;

  // trap wins over mret when both are presented
  assign accept = (state == IDLE) && (bus.trap_valid || bus.mret_valid);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // next state and state-decoded control outputs
  always_comb begin
    state_n     = state;
    req_ready   = 1'b0;
    busy        = 1'b1;
    flush       = 1'b0;
    redir_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (accept) state_n = FLUSH;
      end
      FLUSH: begin
        flush = 1'b1;
        if (fcnt == '0) state_n = DRAIN;
      end
      DRAIN:    if (bus.lsu_idle && pend == '0) state_n = EFFECT;
      EFFECT:   state_n = REDIRECT;
      REDIRECT: begin
        redir_valid = 1'b1;
        if (bus.redir_ready) state_n = IDLE;
      end
      default:  state_n = IDLE;
    endcase
  end

  // request latch, flush counter and redirect target
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt       <= '0;
      kind       <= EX;
      cause      <= INSTR_MISALIGN;
      epc        <= '0;
      tval       <= '0;
      redir_pc_q <= '0;
    end else begin
      if (accept) begin
        kind  <= bus.trap_valid ? EX : RET;
        cause <= bus.trap_cause;
        epc   <= bus.trap_epc;
        tval  <= bus.trap_tval;
        fcnt  <= CNT_W'(FLUSH_CYCLES - 1);
      end else if (state == FLUSH && fcnt != '0) begin
        fcnt <= fcnt - CNT_W'(1);
      end
      if (state == EFFECT) redir_pc_q <= (kind == EX) ? bus.csr_mtvec : bus.csr_mepc;
    end
  end

  // deferred retires: parked during the EX/RET cycle, released one per idle effect slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
    end else if (state == EFFECT) begin
      if (bus.retire && pend != PEND_MAX) pend <= pend + PEND_W'(1);
    end else if (!bus.retire && pend != '0) begin
      pend <= pend - PEND_W'(1);
    end
  end

  // effect mux: EX/RET beats INSTRET beats NONE
  always_comb begin
    eff = '0;
    if (state == EFFECT) begin
      if (kind == EX) begin
        eff.t    = CSR_EFF_EX;
        eff.src  = cause;
        eff.epc  = epc;
        eff.tval = tval;
      end else begin
        eff.t = CSR_EFF_RET;
      end
    end else if (bus.retire || pend != '0) begin
      eff.t = CSR_EFF_INSTRET;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.busy        = busy;
  assign bus.flush       = flush;
  assign bus.redir_valid = redir_valid;
  assign bus.redir_pc    = redir_pc_q;
  assign bus.effect      = eff;

  a_pend_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(state == EFFECT && bus.retire && pend == PEND_MAX));
  a_flush_redir: assert property (@(posedge clk) disable iff (!rst)
    !(flush && redir_valid));

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed sequences for the trap sequencer followed by a randomized run
// scored against a transaction-level model (request queue + retire accounting).
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  localparam int FC = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trap_ctrl_if bus();
  trap_ctrl #(.FLUSH_CYCLES(FC), .PEND_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int passed = 0, total = 0, fails = 0;

  typedef struct {
    trap_kind_e  k;
    ex_cause     c;
    logic [31:0] epc, tval, tgt;
  } txn_t;

  txn_t    q[$];
  ex_cause tbl[9] = '{INSTR_MISALIGN, INSTR_FAULT, ILLEGAL_INSTR, BREAKPOINT, LOAD_MISALIGN,
                      LOAD_FAULT, STORE_MISALIGN, STORE_FAULT, ECALL_M};
  logic    req_on = 1'b0, req_trap = 1'b0, req_mret = 1'b0;
  int      retires = 0, instrets = 0, flush_run = 0, accepted = 0, completed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.trap_valid  = 1'b0;
    bus.mret_valid  = 1'b0;
    bus.trap_cause  = INSTR_MISALIGN;
    bus.trap_epc    = '0;
    bus.trap_tval   = '0;
    bus.retire      = 1'b0;
    bus.lsu_idle    = 1'b1;
    bus.redir_ready = 1'b1;
  endtask

  // model-side bookkeeping for one cycle of the random run
  task automatic observe();
    txn_t t;
    if (bus.retire) retires++;
    if (bus.effect.t == CSR_EFF_INSTRET) instrets++;
    if (bus.flush) flush_run++;
    chk("flush_redir_exclusive", 32'(bus.flush & bus.redir_valid), 32'd0);
    if (bus.effect.t == CSR_EFF_EX || bus.effect.t == CSR_EFF_RET) begin
      chk("effect_has_txn", 32'(q.size()), 32'd1);
      if (q.size() > 0) begin
        t = q[0];
        chk("rnd_kind", 32'(bus.effect.t), 32'((t.k == EX) ? CSR_EFF_EX : CSR_EFF_RET));
        if (t.k == EX) begin
          chk("rnd_src", 32'(bus.effect.src), 32'(t.c));
          chk("rnd_epc", bus.effect.epc, t.epc);
          chk("rnd_tval", bus.effect.tval, t.tval);
        end
      end
      chk("rnd_flush_len", 32'(flush_run), 32'(FC));
      flush_run = 0;
    end
    if (bus.redir_valid && bus.redir_ready) begin
      chk("redir_has_txn", 32'(q.size()), 32'd1);
      if (q.size() > 0) begin
        chk("rnd_redir_pc", bus.redir_pc, q[0].tgt);
        void'(q.pop_front());
        completed++;
      end
    end
    if (req_on && bus.req_ready) begin
      t.k    = req_trap ? EX : RET;
      t.c    = bus.trap_cause;
      t.epc  = bus.trap_epc;
      t.tval = bus.trap_tval;
      t.tgt  = req_trap ? bus.csr_mtvec : bus.csr_mepc;
      q.push_back(t);
      accepted++;
      req_on = 1'b0;
    end
  endtask

  initial begin
    quiet();
    bus.csr_mtvec = 32'h8000_0000;
    bus.csr_mepc  = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flush", 32'(bus.flush), 0);
    chk("rst_redir_valid", 32'(bus.redir_valid), 0);
    chk("rst_redir_pc", bus.redir_pc, 0);
    chk("rst_effect", 32'(bus.effect.t), 32'(CSR_EFF_NONE));
    rst = 1'b1;
    #1;
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_req_ready", 32'(bus.req_ready), 1);

    // illegal instruction trap, one flush cycle, drain already satisfied
    cyc();
    bus.trap_valid = 1'b1; bus.trap_cause = ILLEGAL_INSTR;
    bus.trap_epc = 32'h100; bus.trap_tval = 32'hDEAD; bus.csr_mtvec = 32'h8000_0000;
    #1 chk("t2_req_ready", 32'(bus.req_ready), 1);
    cyc(); bus.trap_valid = 1'b0;
    #1 chk("t2_flush", 32'(bus.flush), 1);
    chk("t2_busy", 32'(bus.busy), 1);
    chk("t2_req_ready_busy", 32'(bus.req_ready), 0);
    cyc();
    #1 chk("t2_flush_len", 32'(bus.flush), 0);
    chk("t2_drain_effect", 32'(bus.effect.t), 32'(CSR_EFF_NONE));
    cyc();
    #1 chk("t2_eff_t", 32'(bus.effect.t), 32'(CSR_EFF_EX));
    chk("t2_eff_src", 32'(bus.effect.src), 32'(ILLEGAL_INSTR));
    chk("t2_eff_epc", bus.effect.epc, 32'h100);
    chk("t2_eff_tval", bus.effect.tval, 32'hDEAD);
    cyc();
    #1 chk("t2_redir_valid", 32'(bus.redir_valid), 1);
    chk("t2_redir_pc", bus.redir_pc, 32'h8000_0000);
    chk("t2_single_effect", 32'(bus.effect.t), 32'(CSR_EFF_NONE));
    cyc();
    #1 chk("t2_done", 32'(bus.busy), 0);

    // fetch stalls the redirect for 3 cycles while commit keeps presenting mret
    cyc();
    bus.trap_valid = 1'b1; bus.trap_cause = LOAD_FAULT;
    bus.trap_epc = 32'h300; bus.trap_tval = 32'h44;
    bus.csr_mtvec = 32'h8000_0040; bus.redir_ready = 1'b0;
    cyc(); bus.trap_valid = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.csr_mtvec = 32'hFFFF_0000;
      bus.mret_valid = 1'b1;
      #1 chk("t6_redir_valid", 32'(bus.redir_valid), 1);
      chk("t6_redir_pc", bus.redir_pc, 32'h8000_0040);
      chk("t6_req_ready", 32'(bus.req_ready), 0);
    end
    cyc(); bus.mret_valid = 1'b0; bus.redir_ready = 1'b1;
    #1 chk("t6_redir_hold", 32'(bus.redir_valid), 1);
    cyc();
    #1 chk("t6_release", 32'(bus.redir_valid), 0);
    cyc();
    #1 chk("t6_mret_ignored", 32'(bus.busy), 0);

    // asynchronous reset while redirect is pending
    bus.csr_mtvec = 32'h8000_0000;
    cyc(); bus.trap_valid = 1'b1; bus.redir_ready = 1'b0;
    cyc(); bus.trap_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    #1 chk("t1_in_redirect", 32'(bus.redir_valid), 1);
    #2 rst = 1'b0;
    #1 chk("t1_redir_valid", 32'(bus.redir_valid), 0);
    chk("t1_effect", 32'(bus.effect.t), 32'(CSR_EFF_NONE));
    chk("t1_busy", 32'(bus.busy), 0);
    chk("t1_redir_pc", bus.redir_pc, 0);
    bus.redir_ready = 1'b1;
    cyc(); rst = 1'b1;
    #1 chk("t1_req_ready", 32'(bus.req_ready), 1);

    // mret with the LSU busy for 5 drain cycles
    cyc();
    bus.mret_valid = 1'b1; bus.csr_mepc = 32'h204; bus.lsu_idle = 1'b0;
    cyc(); bus.mret_valid = 1'b0;
    #1 chk("t3_flush", 32'(bus.flush), 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1 chk("t3_drain_hold", 32'(bus.effect.t), 32'(CSR_EFF_NONE));
      chk("t3_drain_busy", 32'(bus.busy & ~bus.flush & ~bus.redir_valid), 1);
    end
    cyc(); bus.lsu_idle = 1'b1;
    #1 chk("t3_drain_exit", 32'(bus.effect.t), 32'(CSR_EFF_NONE));
    cyc();
    #1 chk("t3_ret", 32'(bus.effect.t), 32'(CSR_EFF_RET));
    cyc();
    #1 chk("t3_redir_pc", bus.redir_pc, 32'h204);
    chk("t3_no_instret", 32'(bus.effect.t), 32'(CSR_EFF_NONE));
    cyc();

    // trap and mret together: trap wins
    cyc();
    bus.trap_valid = 1'b1; bus.mret_valid = 1'b1; bus.trap_cause = ECALL_M;
    bus.trap_epc = 32'h500; bus.trap_tval = 32'h0;
    bus.csr_mtvec = 32'h8000_0100; bus.csr_mepc = 32'h999;
    cyc(); bus.trap_valid = 1'b0; bus.mret_valid = 1'b0;
    cyc();
    cyc();
    #1 chk("t4_eff_t", 32'(bus.effect.t), 32'(CSR_EFF_EX));
    chk("t4_eff_src", 32'(bus.effect.src), 32'(ECALL_M));
    cyc();
    #1 chk("t4_redir_pc", bus.redir_pc, 32'h8000_0100);
    cyc();

    // retire alongside acceptance, then retire colliding with the EX cycle
    cyc();
    bus.trap_valid = 1'b1; bus.retire = 1'b1; bus.trap_cause = BREAKPOINT;
    bus.trap_epc = 32'h600; bus.trap_tval = 32'h600;
    #1 chk("t5_accept_instret", 32'(bus.effect.t), 32'(CSR_EFF_INSTRET));
    cyc(); bus.trap_valid = 1'b0; bus.retire = 1'b0;
    #1 chk("t5_no_extra", 32'(bus.effect.t), 32'(CSR_EFF_NONE));
    cyc();
    cyc(); bus.retire = 1'b1;
    #1 chk("t5_ex_wins", 32'(bus.effect.t), 32'(CSR_EFF_EX));
    cyc(); bus.retire = 1'b0;
    #1 chk("t5_deferred", 32'(bus.effect.t), 32'(CSR_EFF_INSTRET));
    cyc();
    #1 chk("t5_pend_clear", 32'(bus.effect.t), 32'(CSR_EFF_NONE));

    // randomized traffic
    for (int cy = 0; cy < 3000; cy++) begin
      cyc();
      if (!req_on && q.size() == 0 && $urandom_range(0, 3) == 0) begin
        int r;
        r = $urandom_range(0, 2);
        req_on   = 1'b1;
        req_trap = (r != 1);
        req_mret = (r != 0);
        bus.trap_cause = tbl[$urandom_range(0, 8)];
        bus.trap_epc   = $urandom;
        bus.trap_tval  = $urandom;
        bus.csr_mtvec  = $urandom & 32'hFFFF_FFFC;
        bus.csr_mepc   = $urandom;
      end
      bus.trap_valid  = req_on & req_trap;
      bus.mret_valid  = req_on & req_mret;
      bus.retire      = ($urandom_range(0, 2) == 0);
      bus.lsu_idle    = ($urandom_range(0, 2) != 0);
      bus.redir_ready = ($urandom_range(0, 1) == 1);
      #1 observe();
    end
    for (int cy = 0; cy < 40; cy++) begin
      cyc();
      bus.trap_valid  = req_on & req_trap;
      bus.mret_valid  = req_on & req_mret;
      bus.retire      = 1'b0;
      bus.lsu_idle    = 1'b1;
      bus.redir_ready = 1'b1;
      #1 observe();
    end
    chk("instret_conservation", 32'(instrets), 32'(retires));
    chk("queue_drained", 32'(q.size()), 0);
    chk("request_taken", 32'(req_on), 0);
    chk("completed_vs_accepted", 32'(completed), 32'(accepted));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
